// File: rtl/sumador_normalizador.sv
// sumador_normalizador: add/subtract and renormalise stage of the single-precision
// floating-point adder. Takes the two aligned 26-bit mantissas and the common
// biased exponent, and returns sign, exponent and truncated 23-bit fraction over
// a valid/ready handshake.
// Optional macro SUMADOR_NORM_RAPIDA_EN: single-cycle normalisation through a
// combinational leading-zero counter. When it is undefined, normalisation
// shifts one bit per cycle.
module sumador_normalizador (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Signo_A,
  input  logic        Signo_B,
  input  logic [25:0] Mantissa_A,
  input  logic [25:0] Mantissa_B,
  input  logic [7:0]  Exp_comun,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Signo_R,
  output logic [7:0]  Exponente_R,
  output logic [22:0] Mantissa_R,
  output logic        Overflow,
  output logic        Zero
);

  typedef enum logic [1:0] {IDLE, SUMA, NORM, SALIDA} state_t;

  state_t      state, state_n;

  // Captured operands
  logic        sa, sb;
  logic [25:0] ma, mb;
  logic [7:0]  ea;

  // Working result. It also drives the outputs, which are only valid in SALIDA.
  logic [25:0] mag, mag_n;
  logic [8:0]  expo, expo_n;
  logic        sign, sign_n;
  logic        ovf, ovf_n;
  logic        zero, zero_n;

`ifdef SUMADOR_NORM_RAPIDA_EN
  logic [4:0]  lz;

  // Leading zeros of mag[23:0]. The highest set bit wins, because later loop
  // iterations overwrite earlier ones.
  always_comb begin
    lz = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (mag[i]) lz = 5'(23 - i);
    end
  end
`endif

  // Next-state and next-datapath logic
  always_comb begin
    state_n = state;
    mag_n   = mag;
    expo_n  = expo;
    sign_n  = sign;
    ovf_n   = ovf;
    zero_n  = zero;
    case (state)
      IDLE: begin
        if (in_valid) state_n = SUMA;
      end
      SUMA: begin
        ovf_n  = 1'b0;
        zero_n = 1'b0;
        expo_n = {1'b0, ea};
        if (sa == sb) begin
          mag_n  = ma + mb;
          sign_n = sa;
        end else if (ma > mb) begin
          mag_n  = ma - mb;
          sign_n = sa;
        end else if (mb > ma) begin
          mag_n  = mb - ma;
          sign_n = sb;
        end else begin
          mag_n  = '0;
          sign_n = 1'b0;
        end
        state_n = NORM;
      end
      NORM: begin
        if (mag == '0) begin
          zero_n  = 1'b1;
          expo_n  = '0;
          state_n = SALIDA;
        end else if (mag[24]) begin
          mag_n  = mag >> 1;
          expo_n = expo + 9'd1;
          if (expo + 9'd1 >= 9'd255) begin
            ovf_n   = 1'b1;
            expo_n  = 9'd255;
            mag_n   = '0;
            state_n = SALIDA;
          end
`ifdef SUMADOR_NORM_RAPIDA_EN
          else begin
            state_n = SALIDA;
          end
`endif
        end else if (mag[23]) begin
          state_n = SALIDA;
        end else begin
`ifdef SUMADOR_NORM_RAPIDA_EN
          // Same flush rule as the iterative walk: underflow when the
          // exponent would reach zero or below.
          if ({4'b0, lz} >= expo) begin
            zero_n = 1'b1;
            expo_n = '0;
            mag_n  = '0;
          end else begin
            mag_n  = mag << lz;
            expo_n = expo - {4'b0, lz};
          end
          state_n = SALIDA;
`else
          if (expo <= 9'd1) begin
            zero_n  = 1'b1;
            expo_n  = '0;
            mag_n   = '0;
            state_n = SALIDA;
          end else begin
            mag_n  = mag << 1;
            expo_n = expo - 9'd1;
          end
`endif
        end
      end
      SALIDA: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand capture and working-result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= 1'b0;
      sb   <= 1'b0;
      ma   <= '0;
      mb   <= '0;
      ea   <= '0;
      mag  <= '0;
      expo <= '0;
      sign <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sa <= Signo_A;
        sb <= Signo_B;
        ma <= Mantissa_A;
        mb <= Mantissa_B;
        ea <= Exp_comun;
      end
      mag  <= mag_n;
      expo <= expo_n;
      sign <= sign_n;
      ovf  <= ovf_n;
      zero <= zero_n;
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == SALIDA);
  assign Signo_R     = sign;
  assign Exponente_R = expo[7:0];
  assign Mantissa_R  = mag[22:0];
  assign Overflow    = ovf;
  assign Zero        = zero;

endmodule

// File: doc/sumador_normalizador.md
# sumador_normalizador

Sequential add/subtract and normalise stage placed directly downstream of the exponent-alignment (denormaliser) stage in the single-precision floating-point adder. It consumes the two aligned 26-bit mantissas and the common biased exponent, adds or subtracts them by sign, and renormalises the result. It delivers sign, biased exponent and 23-bit fraction through a valid/ready handshake. Normalisation is iterative, one bit per cycle, unless the fast-normalise option is compiled in.

## Interface
- No parameters; widths fixed to IEEE-754 single precision.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- Signo_A, Signo_B  in  1 each  operand signs.
- Mantissa_A, Mantissa_B  in  26  aligned mantissas; hidden bit at [23], [25:24] zero.
- Exp_comun  in  8  common biased exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- Signo_R  out  1  result sign.
- Exponente_R  out  8  result biased exponent.
- Mantissa_R  out  23  result fraction, hidden bit dropped, truncated.
- Overflow  out  1  result exponent reached 255 (result is infinity).
- Zero  out  1  result is exactly zero or flushed underflow.

## Operation
- FSM states: IDLE, SUMA, NORM, SALIDA.
- IDLE: in_ready=1. When in_valid&in_ready is high at an edge, register all inputs and go to SUMA.
- SUMA, one cycle:
  - Equal signs: 26-bit sum = A+B; sign = Signo_A.
  - Different signs: magnitude = larger − smaller; sign = sign of the larger operand.
  - Equal magnitudes: result 0, sign 0.
  - Register the result and Exp_comun, then go to NORM.
- NORM, one step per cycle, checks in this priority order:
  - Magnitude 0: Zero=1, exponent 0, fraction 0 → SALIDA.
  - Bit [24] set: shift right 1 (LSB truncated), exponent+1. If the new exponent is 255: Overflow=1, fraction 0 → SALIDA.
  - Bit [23] set: normalised → SALIDA.
  - Otherwise: shift left 1, exponent−1. If the exponent reaches 0: flush to zero (Zero=1, sign kept, fraction 0) → SALIDA.
- SALIDA: out_valid=1 and outputs are held stable. When out_valid&out_ready is high at an edge, go to IDLE.
- Arithmetic: the 26-bit datapath cannot overflow (max sum 25 bits). Exponent arithmetic uses 9 bits internally and is checked before truncation to 8 bits.
- rst at any edge, in any state, including mid-NORM: go to IDLE and discard the operation. No output is produced for it.

## Timing
- Reset values: out_valid=0, Signo_R=0, Exponente_R=0, Mantissa_R=0, Overflow=0, Zero=0. in_ready=1 from the first cycle after rst is released.
- Latency, operands accepted at edge N: out_valid is high starting in the cycle after edge N+2+k.
  - k = 0 if already normalised or zero.
  - k = 1 for a carry shift-right.
  - k = leading-zero count (max 23) for left shifts.
- Throughput: one operation in flight. in_ready=0 from SUMA until return to IDLE.
- Backpressure: with out_ready=0, out_valid and all result outputs stay constant indefinitely.
- out_ready is ignored outside SALIDA. in_valid is ignored outside IDLE.

## Configuration
- SUMADOR_NORM_RAPIDA_EN defined:
  - NORM completes in exactly one cycle, so k=0 always and latency is fixed at edge N+2.
  - A combinational leading-zero counter computes the full shift.
  - Underflow rule: if leading zeros ≥ exponent, flush to zero.
- Undefined: the iterative one-bit-per-cycle NORM above.
- Results (sign, exponent, fraction, flags) are identical in both builds; only latency differs.

## Test plan
- 1.0+1.0: A=B=0x0800000, exp 127, signs 0 → Exponente_R=128, Mantissa_R=0, Signo_R=0; out_valid after edge N+3 (iterative).
- 1.5−1.0: A=0x0C00000 sign 0, B=0x0800000 sign 1, exp 127 → exp 126, fraction 0, sign 0, k=1.
- Equal magnitudes, opposite signs (0x0A00000, exp 100) → Zero=1, exp 0, fraction 0, sign 0.
- Exp_comun=254, A=B=0x0FFFFFF, same signs → Overflow=1, exp 255, fraction 0.
- A=0x0800001 sign 0, B=0x0800000 sign 1, exp 10 → underflow flush: Zero=1, exp 0. Also check the k=23 path with exp 127: result exp 104, out_valid after edge N+25 (iterative) or N+2 (SUMADOR_NORM_RAPIDA_EN).
- Hold out_ready=0 for 5 cycles in SALIDA → outputs stable, in_ready=0. Separately, assert rst mid-NORM → out_valid stays 0, in_ready=1 the next cycle.
